// File: rtl/uart_bus_arbiter.sv
// Bus master for UART_Component: polls the control register, drains Rx bytes to one
// consumer and arbitrates two Tx byte streams round-robin onto the UART Tx buffer.
module uart_bus_arbiter #(
    parameter int SETUP_CYCLES = 2,
    parameter int READ_CYCLES  = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int RX_AVAIL_BIT = 0,
    parameter int TX_BUSY_BIT  = 1
) (
    input  logic       clock,
    input  logic       reset,
    output logic       uart_cs,
    output logic       uart_rd,
    output logic       uart_wr,
    output logic [2:0] uart_addr,
    output logic [7:0] uart_in_data,
    input  logic [7:0] uart_out_data,
    input  logic [1:0] tx_valid,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_DECIDE,
        S_RX_RD,
        S_TX_SETUP,
        S_TX_STROBE,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic       r_cs, r_rd, r_wr;
    logic [2:0] r_addr;
    logic [7:0] r_in_data;
    logic [1:0] r_tx_ready;
    logic       r_last_grant;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_stat_rx_avail;
    logic       r_stat_tx_busy;

    logic       w_cs_nxt, w_rd_nxt, w_wr_nxt;
    logic [2:0] w_addr_nxt;
    logic [7:0] w_in_data_nxt;
    logic [1:0] w_tx_ready_nxt;
    logic       w_last_grant_nxt;

    logic w_read_last, w_setup_last, w_gap_last;
    logic w_rx_go, w_tx_go, w_grant;

    assign w_read_last  = (r_cnt == CNT_W'(READ_CYCLES - 1));
    assign w_setup_last = (r_cnt == CNT_W'(SETUP_CYCLES - 1));
    assign w_gap_last   = (r_cnt == CNT_W'(GAP_CYCLES - 1));

    // Rx is checked first so a pending byte always beats a pending Tx write
    assign w_rx_go = r_stat_rx_avail && !r_rx_valid;
    assign w_tx_go = !r_stat_tx_busy && (tx_valid != 2'b00);
    assign w_grant = (tx_valid == 2'b11) ? ~r_last_grant : tx_valid[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      w_state_nxt = S_POLL;
            S_POLL:      if (w_read_last) w_state_nxt = S_DECIDE;
            S_DECIDE: begin
                if (w_rx_go)      w_state_nxt = S_RX_RD;
                else if (w_tx_go) w_state_nxt = S_TX_SETUP;
                else              w_state_nxt = S_POLL;
            end
            S_RX_RD:     if (w_read_last) w_state_nxt = S_GAP;
            S_TX_SETUP:  if (w_setup_last) w_state_nxt = S_TX_STROBE;
            S_TX_STROBE: w_state_nxt = S_GAP;
            S_GAP:       if (w_gap_last) w_state_nxt = S_POLL;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they are registered yet aligned to it
    always_comb begin
        w_cs_nxt         = 1'b1;
        w_rd_nxt         = 1'b1;
        w_wr_nxt         = 1'b1;
        w_addr_nxt       = r_addr;
        w_in_data_nxt    = r_in_data;
        w_tx_ready_nxt   = 2'b00;
        w_last_grant_nxt = r_last_grant;
        case (w_state_nxt)
            S_POLL: begin
                w_cs_nxt   = 1'b0;
                w_rd_nxt   = 1'b0;
                w_addr_nxt = 3'd0;
            end
            S_RX_RD: begin
                w_cs_nxt   = 1'b0;
                w_rd_nxt   = 1'b0;
                w_addr_nxt = 3'd1;
            end
            S_TX_SETUP:  w_cs_nxt = 1'b0;
            S_TX_STROBE: begin
                w_cs_nxt = 1'b0;
                w_wr_nxt = 1'b0;
            end
            default: ;
        endcase
        if (r_state == S_DECIDE && w_state_nxt == S_TX_SETUP) begin
            w_addr_nxt       = 3'd2;
            w_in_data_nxt    = w_grant ? tx_data1 : tx_data0;
            w_tx_ready_nxt   = w_grant ? 2'b10 : 2'b01;
            w_last_grant_nxt = w_grant;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cs            <= 1'b1;
            r_rd            <= 1'b1;
            r_wr            <= 1'b1;
            r_addr          <= 3'd0;
            r_in_data       <= 8'd0;
            r_tx_ready      <= 2'b00;
            r_last_grant    <= 1'b1;
            r_rx_valid      <= 1'b0;
            r_rx_data       <= 8'd0;
            r_stat_rx_avail <= 1'b0;
            r_stat_tx_busy  <= 1'b0;
        end else begin
            r_cs         <= w_cs_nxt;
            r_rd         <= w_rd_nxt;
            r_wr         <= w_wr_nxt;
            r_addr       <= w_addr_nxt;
            r_in_data    <= w_in_data_nxt;
            r_tx_ready   <= w_tx_ready_nxt;
            r_last_grant <= w_last_grant_nxt;
            if (r_state == S_POLL && w_read_last) begin
                r_stat_rx_avail <= uart_out_data[RX_AVAIL_BIT];
                r_stat_tx_busy  <= uart_out_data[TX_BUSY_BIT];
            end
            if (r_state == S_RX_RD && w_read_last) begin
                r_rx_data  <= uart_out_data;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign uart_cs      = r_cs;
    assign uart_rd      = r_rd;
    assign uart_wr      = r_wr;
    assign uart_addr    = r_addr;
    assign uart_in_data = r_in_data;
    assign tx_ready     = r_tx_ready;
    assign rx_valid     = r_rx_valid;
    assign rx_data      = r_rx_data;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Randomized bench for uart_bus_arbiter: a UART/requester model predicts each bus
// transaction at poll time; a separate monitor decodes the bus and checks it.
module tb_uart_bus_arbiter;

    localparam int SETUP_CYCLES = 2;
    localparam int READ_CYCLES  = 2;
    localparam int GAP_CYCLES   = 2;
    localparam int K_POLL = 0;
    localparam int K_RX   = 1;
    localparam int K_WR   = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       uart_cs, uart_rd, uart_wr;
    logic [2:0] uart_addr;
    logic [7:0] uart_in_data;
    logic [7:0] uart_out_data = 8'd0;
    logic [1:0] tx_valid = 2'b00;
    logic [7:0] tx_data0 = 8'd0;
    logic [7:0] tx_data1 = 8'd0;
    logic [1:0] tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;

    uart_bus_arbiter #(
        .SETUP_CYCLES(SETUP_CYCLES),
        .READ_CYCLES (READ_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .RX_AVAIL_BIT(0),
        .TX_BUSY_BIT (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart_cs      (uart_cs),
        .uart_rd      (uart_rd),
        .uart_wr      (uart_wr),
        .uart_addr    (uart_addr),
        .uart_in_data (uart_in_data),
        .uart_out_data(uart_out_data),
        .tx_valid     (tx_valid),
        .tx_data0     (tx_data0),
        .tx_data1     (tx_data1),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    typedef struct {
        int kind;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   rdy_q[$];

    // UART and requester model state
    logic [7:0] req_q0[$];
    logic [7:0] req_q1[$];
    logic [7:0] rx_fifo[$];
    logic [7:0] cur_status = 8'd0;
    bit         en0, en1, pop0, pop1;
    int         m_last;
    bit         m_rxv;
    bit         d_prev_cs;
    int         d_win_addr;
    int         p_busy, p_rxpush, p_ready, p_en, p_refill;

    task automatic push_exp(input int kind, input int data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic update_tx();
        tx_valid[0] = en0 && (req_q0.size() > 0);
        tx_valid[1] = en1 && (req_q1.size() > 0);
        tx_data0    = (req_q0.size() > 0) ? req_q0[0] : 8'($urandom);
        tx_data1    = (req_q1.size() > 0) ? req_q1[0] : 8'($urandom);
    endtask

    // What the arbiter must do after a poll, from the status it read and the requests it sees
    task automatic predict();
        int w;
        if (cur_status[0] && !m_rxv) begin
            push_exp(K_RX, int'(rx_fifo[0]));
        end else if (!cur_status[1] && tx_valid != 2'b00) begin
            if (tx_valid == 2'b11) w = 1 - m_last;
            else                   w = tx_valid[1] ? 1 : 0;
            m_last = w;
            push_exp(K_WR, int'(w ? req_q1[0] : req_q0[0]));
            rdy_q.push_back(w);
        end else begin
            push_exp(K_POLL, 0);
        end
    endtask

    task automatic drv_step();
        if (m_rxv && rx_ready) m_rxv = 1'b0;
        if (pop0) begin void'(req_q0.pop_front()); pop0 = 1'b0; end
        if (pop1) begin void'(req_q1.pop_front()); pop1 = 1'b0; end
        if (tx_ready[0]) pop0 = 1'b1;
        if (tx_ready[1]) pop1 = 1'b1;
        if (d_prev_cs && !uart_cs) begin
            d_win_addr = int'(uart_addr);
            if (uart_addr == 3'd0) begin
                if (roll(p_rxpush)) rx_fifo.push_back(8'($urandom));
                if (req_q0.size() < 3 && roll(p_refill)) req_q0.push_back(8'($urandom));
                if (req_q1.size() < 3 && roll(p_refill)) req_q1.push_back(8'($urandom));
                en0 = roll(p_en);
                en1 = roll(p_en);
                cur_status    = 8'($urandom);
                cur_status[0] = (rx_fifo.size() > 0);
                cur_status[1] = roll(p_busy);
            end
        end
        update_tx();
        if (!d_prev_cs && uart_cs) begin
            if (d_win_addr == 0) begin
                predict();
            end else begin
                if (d_win_addr == 1) begin
                    if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
                    m_rxv = 1'b1;
                end
                push_exp(K_POLL, 0);
            end
        end
        if (!uart_cs && !uart_rd && uart_addr == 3'd0)
            uart_out_data = cur_status;
        else if (!uart_cs && !uart_rd && uart_addr == 3'd1)
            uart_out_data = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'hEE;
        else
            uart_out_data = 8'($urandom);
        rx_ready  = roll(p_ready);
        d_prev_cs = uart_cs;
    endtask

    // Bus monitor state
    bit         mp_cs = 1'b1;
    bit         in_win, first_win, w_unstable, w_clash, w_rdy, w_wrlast, ended_rx;
    int         w_addr, w_data, w_len, w_rdlow, w_wrlow, idle_cnt, last_kind;
    bit         prev_rxv;
    logic [7:0] prev_rxd;
    logic [7:0] acc_q[$];
    int         n_wr = 0;
    int         n_rx = 0;

    task automatic finalize();
        exp_t e;
        int   kind;
        kind = (w_addr <= 2) ? w_addr : 3;
        chk("rd_wr_clash", int'(w_clash), 0);
        chk("addr_data_stable", int'(w_unstable), 0);
        if (exp_q.size() == 0) begin
            chk("unexpected_window", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk("win_kind", kind, e.kind);
            if (e.kind == K_WR) begin
                n_wr++;
                chk("wr_len", w_len, SETUP_CYCLES + 1);
                chk("wr_rdlow", w_rdlow, 0);
                chk("wr_wrlow", w_wrlow, 1);
                chk("wr_strobe_last", int'(w_wrlast), 1);
                chk("wr_data", w_data, e.data);
                chk("wr_ready_seen", int'(w_rdy), 1);
            end else begin
                chk("rd_len", w_len, READ_CYCLES);
                chk("rd_rdlow", w_rdlow, READ_CYCLES);
                chk("rd_wrlow", w_wrlow, 0);
                if (e.kind == K_RX) begin
                    n_rx++;
                    chk("rx_valid_set", int'(rx_valid), 1);
                    chk("rx_data", int'(rx_data), e.data);
                    acc_q.push_back(8'(e.data));
                    ended_rx = 1'b1;
                end
            end
        end
        last_kind = kind;
    endtask

    task automatic mon_step();
        int w;
        logic [7:0] b;
        if (!reset) begin
            mp_cs = 1'b1; in_win = 1'b0; first_win = 1'b1; prev_rxv = 1'b0;
            idle_cnt = 0; acc_q.delete();
            return;
        end
        ended_rx = 1'b0;
        if (prev_rxv && rx_ready) begin
            chk("rx_clear", int'(rx_valid), 0);
            chk("rx_accept_count", acc_q.size(), 1);
            if (acc_q.size() > 0) begin
                b = acc_q.pop_front();
                chk("rx_accept_data", int'(prev_rxd), int'(b));
            end
        end
        if (!uart_cs) begin
            if (mp_cs) begin
                if (!first_win) chk("idle_gap", idle_cnt, (last_kind == K_POLL) ? 1 : GAP_CYCLES);
                first_win = 1'b0; in_win = 1'b1;
                w_addr = int'(uart_addr); w_data = int'(uart_in_data);
                w_len = 0; w_rdlow = 0; w_wrlow = 0; w_unstable = 1'b0; w_clash = 1'b0; w_rdy = 1'b0;
            end
            w_len++;
            if (int'(uart_addr) != w_addr || int'(uart_in_data) != w_data) w_unstable = 1'b1;
            if (!uart_rd) w_rdlow++;
            if (!uart_wr) w_wrlow++;
            w_wrlast = !uart_wr;
            if (!uart_rd && !uart_wr) w_clash = 1'b1;
            if (tx_ready != 2'b00) begin
                chk("ready_first_cycle", w_len, 1);
                chk("ready_addr", int'(uart_addr), 2);
                if (rdy_q.size() > 0) begin
                    w = rdy_q.pop_front();
                    chk("tx_ready", int'(tx_ready), w ? 2 : 1);
                end else begin
                    chk("tx_ready_unexpected", int'(tx_ready), 0);
                end
                w_rdy = 1'b1;
            end
        end else begin
            if (tx_ready != 2'b00) chk("tx_ready_bus_idle", int'(tx_ready), 0);
            if (!mp_cs && in_win) begin
                finalize();
                in_win = 1'b0;
                idle_cnt = 0;
            end
            idle_cnt++;
        end
        if (!prev_rxv && rx_valid && !ended_rx) chk("rx_valid_spurious", int'(rx_valid), 0);
        prev_rxv = rx_valid;
        prev_rxd = rx_data;
        mp_cs    = uart_cs;
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        mon_step();
    end

    task automatic model_reset();
        exp_q.delete(); rdy_q.delete();
        m_last = 1; m_rxv = 1'b0; pop0 = 1'b0; pop1 = 1'b0; d_prev_cs = 1'b1;
        push_exp(K_POLL, 0);
    endtask

    task automatic set_probs(input int busy, input int rxp, input int rdy, input int en, input int refill);
        p_busy = busy; p_rxpush = rxp; p_ready = rdy; p_en = en; p_refill = refill;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cs"}, int'(uart_cs), 1);
        chk({tag, "_rd"}, int'(uart_rd), 1);
        chk({tag, "_wr"}, int'(uart_wr), 1);
        chk({tag, "_addr"}, int'(uart_addr), 0);
        chk({tag, "_in_data"}, int'(uart_in_data), 0);
        chk({tag, "_tx_ready"}, int'(tx_ready), 0);
        chk({tag, "_rx_valid"}, int'(rx_valid), 0);
        chk({tag, "_rx_data"}, int'(rx_data), 0);
    endtask

    initial begin
        bit found;
        set_probs(0, 0, 100, 100, 100);
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        model_reset();
        reset = 1'b1;
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: set_probs(0, 0, 100, 100, 100);
                1: set_probs(70, 0, 100, 60, 60);
                2: set_probs(20, 60, 5, 80, 70);
                default: set_probs(30, 30, 50, 70, 60);
            endcase
            repeat (1500) begin
                @(negedge clock);
                drv_step();
            end
        end
        set_probs(0, 0, 100, 100, 100);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            drv_step();
            if (!uart_wr) found = 1'b1;
        end
        chk("write_before_reset", int'(found), 1);
        #2 reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (2) @(negedge clock);
        check_reset_values("held_reset");
        reset = 1'b1;
        set_probs(30, 30, 50, 70, 60);
        repeat (600) begin
            @(negedge clock);
            drv_step();
        end
        chk("writes_seen", int'(n_wr > 20), 1);
        chk("rx_reads_seen", int'(n_rx > 5), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
